// File: rtl/wc_pkg.sv
// rtl/wc_pkg.sv - shared constants and types for the Winograd F(2,3) core
// Contents:
//   TILE, STEP  tile size and stride along a row
//   DEF_DW      default sample width
//   col_width   width of a column counter for a given row length
//   sample_t    one signed sample
//   tile_t      TILE packed samples, index 0 is the oldest
package wc_pkg;

  localparam int TILE   = 4;
  localparam int STEP   = 2;
  localparam int DEF_DW = 10;

  function automatic int col_width(input int row_len);
    return (row_len > 1) ? $clog2(row_len) : 1;
  endfunction

  typedef logic signed [DEF_DW-1:0] sample_t;
  typedef sample_t [TILE-1:0] tile_t;

endpackage

// File: rtl/wc_tile_feeder_if.sv
// rtl/wc_tile_feeder_if.sv - sample-in / tile-out handshake bundle of the feeder
// Signals:
//   s_data/s_valid/s_ready  serial sample stream into the feeder
//   d_data/d_valid/d_ready  packed tile towards WC, d_data[DW-1:0] is d0
//   d_eol                   tile is the last one of its row
// Modports:
//   slave   feeder view
//   master  upstream/WC environment view
interface wc_tile_feeder_if #(
  parameter int DW = wc_pkg::DEF_DW
);
  import wc_pkg::*;

  logic [DW-1:0]      s_data;
  logic               s_valid;
  logic               s_ready;
  logic [TILE*DW-1:0] d_data;
  logic               d_valid;
  logic               d_ready;
  logic               d_eol;

  modport slave (
    input  s_data, s_valid, d_ready,
    output s_ready, d_data, d_valid, d_eol
  );

  modport master (
    output s_data, s_valid, d_ready,
    input  s_ready, d_data, d_valid, d_eol
  );

endinterface

// File: rtl/wc_tile_outreg.sv
// rtl/wc_tile_outreg.sv - one-entry valid/ready output register
// Ports:
//   clk, rst     clock, asynchronous active-low reset
//   clr          synchronous clear of the valid flag (payload kept)
//   load         write in_data; caller only asserts it when load_ready
//   in_data      payload to load
//   load_ready   register is empty or draining this cycle
//   out_data     held payload
//   out_valid    payload not yet consumed
//   out_ready    consumer takes the payload this cycle
module wc_tile_outreg #(
  parameter int W = 41
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] in_data,
  output logic         load_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  assign load_ready = !out_valid || out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (load) begin
      // A load coinciding with a drain replaces the entry, valid stays high.
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/wc_tile_feeder.sv
// rtl/wc_tile_feeder.sv - builds overlapping stride-2 4-sample tiles for WC
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   clr       synchronous clear of partial tile, pending tile and column
//   bus       wc_tile_feeder_if.slave: s_* sample input, d_* tile output
// Parameters:
//   DW        sample width
//   ROW_LEN   samples per row, even and >= 4
module wc_tile_feeder
  import wc_pkg::*;
#(
  parameter int DW      = DEF_DW,
  parameter int ROW_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  wc_tile_feeder_if.slave bus
);

  localparam int CW = col_width(ROW_LEN);
  localparam int OW = TILE*DW + 1;

  // Slot 3 is never stored: the completing sample goes straight to the
  // output register together with slots 0..2.
  logic [DW-1:0] b0, b1, b2;
  logic [1:0]    fill;
  logic [CW-1:0] col;

  logic          s_ready;
  logic          accept;
  logic          complete;
  logic          last_col;
  logic          load_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;

  assign last_col = (col == CW'(ROW_LEN-1));

  // Only a completing sample needs room in the output register; this is
  // combinational in d_ready so a drain and a completion can share a cycle.
  assign s_ready  = !clr && ((fill != 2'd3) || load_ready);
  assign accept   = bus.s_valid && s_ready;
  assign complete = accept && (fill == 2'd3);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b0   <= '0;
      b1   <= '0;
      b2   <= '0;
      fill <= '0;
      col  <= '0;
    end else if (clr) begin
      fill <= '0;
      col  <= '0;
    end else if (accept) begin
      if (fill == 2'd3) begin
        if (last_col) begin
          fill <= '0;
          col  <= '0;
        end else begin
          // Keep the newest two samples as the overlap of the next tile.
          b0   <= b2;
          b1   <= bus.s_data;
          fill <= 2'(TILE-STEP);
          col  <= col + 1'b1;
        end
      end else begin
        case (fill)
          2'd0:    b0 <= bus.s_data;
          2'd1:    b1 <= bus.s_data;
          default: b2 <= bus.s_data;
        endcase
        fill <= fill + 2'd1;
        col  <= col + 1'b1;
      end
    end
  end

  wc_tile_outreg #(.W(OW)) u_outreg (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .load       (complete),
    .in_data    ({last_col, bus.s_data, b2, b1, b0}),
    .load_ready (load_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (bus.d_ready)
  );

  assign bus.s_ready = s_ready;
  assign bus.d_valid = out_valid;
  assign bus.d_data  = out_data[OW-2:0];
  // The stored end-of-row flag is only meaningful alongside d_valid.
  assign bus.d_eol   = out_data[OW-1] && out_valid;

endmodule

// File: tb/tb_wc_tile_feeder.sv
// tb/tb_wc_tile_feeder.sv - directed self-checking bench for wc_tile_feeder
module tb_wc_tile_feeder;
  import wc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  int   errors = 0;
  int   checks = 0;
  int   drains = 0;
  int   drains_before;

  wc_tile_feeder_if #(.DW(10)) bus ();

  wc_tile_feeder #(.DW(10), .ROW_LEN(8)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (bus.d_valid && bus.d_ready) drains++;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [39:0] pk(input int a, input int b, input int c, input int d);
    return {d[9:0], c[9:0], b[9:0], a[9:0]};
  endfunction

  task automatic send(input int v);
    bus.s_data  = v[9:0];
    bus.s_valid = 1'b1;
    @(negedge clk);
    bus.s_valid = 1'b0;
  endtask

  task automatic expect_tile(input string tag, input logic [39:0] data, input logic eol);
    chk({tag, "_valid"}, bus.d_valid, 1'b1);
    chk({tag, "_data"}, bus.d_data, data);
    chk({tag, "_eol"}, bus.d_eol, eol);
  endtask

  initial begin
    bus.s_data  = '0;
    bus.s_valid = 1'b0;
    bus.d_ready = 1'b1;

    // Reset held with s_valid asserted.
    bus.s_valid = 1'b1;
    bus.s_data  = 10'd5;
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", bus.d_valid, 1'b0);
      chk("rst_data", bus.d_data, 40'h0);
      chk("rst_eol", bus.d_eol, 1'b0);
    end
    bus.s_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_s_ready", bus.s_ready, 1'b1);
    @(negedge clk);

    // Two full rows back-to-back: tiles end at samples 4,6,8,12,14,16.
    for (int k = 1; k <= 16; k++) begin
      send(k);
      if ((k % 2 == 0) && k != 2 && k != 10)
        expect_tile("row_tile", pk(k-3, k-2, k-1, k), (k == 8) || (k == 16));
      else
        chk("row_no_tile", bus.d_valid, 1'b0);
    end

    // Backpressure on the output.
    send(1); send(2); send(3);
    bus.d_ready = 1'b0;
    send(4);
    expect_tile("bp_t1", pk(1, 2, 3, 4), 1'b0);
    bus.s_data = 10'd5; bus.s_valid = 1'b1;
    #1 chk("bp_ready5", bus.s_ready, 1'b1);
    @(negedge clk);
    chk("bp_hold1", bus.d_data, pk(1, 2, 3, 4));
    bus.s_data = 10'd6;
    #1 chk("bp_stall6", bus.s_ready, 1'b0);
    @(negedge clk);
    chk("bp_hold2_valid", bus.d_valid, 1'b1);
    chk("bp_hold2_data", bus.d_data, pk(1, 2, 3, 4));
    bus.d_ready = 1'b1;
    #1 chk("bp_ready6", bus.s_ready, 1'b1);
    @(negedge clk);
    bus.s_valid = 1'b0;
    expect_tile("bp_t2", pk(3, 4, 5, 6), 1'b0);
    send(7);
    chk("bp_drained", bus.d_valid, 1'b0);
    send(8);
    expect_tile("bp_t3", pk(5, 6, 7, 8), 1'b1);

    // Signed extremes pass through bit-exact.
    send(10'h200); send(10'h1FF); send(10'h000); send(10'h3FF);
    expect_tile("sgn", 40'hFF_C0_07_FE_00, 1'b0);

    // Asynchronous reset mid-row with a pending tile.
    send(1);
    bus.d_ready = 1'b0;
    send(2);
    send(3);
    chk("pre_rst_pending", bus.d_valid, 1'b1);
    rst = 1'b0;
    #2;
    chk("mid_rst_valid", bus.d_valid, 1'b0);
    chk("mid_rst_data", bus.d_data, 40'h0);
    rst = 1'b1;
    bus.d_ready = 1'b1;
    @(negedge clk);
    send(20); send(21); send(22);
    chk("post_rst_no_tile", bus.d_valid, 1'b0);
    send(23);
    expect_tile("post_rst", pk(20, 21, 22, 23), 1'b0);

    // Synchronous clear with a pending tile that must never be drained.
    send(1);
    bus.d_ready = 1'b0;
    send(2);
    expect_tile("pre_clr", pk(22, 23, 1, 2), 1'b0);
    send(3);
    drains_before = drains;
    clr = 1'b1;
    bus.s_data = 10'd99; bus.s_valid = 1'b1;
    #1 chk("clr_s_ready", bus.s_ready, 1'b0);
    @(negedge clk);
    clr = 1'b0;
    bus.s_valid = 1'b0;
    chk("clr_valid", bus.d_valid, 1'b0);
    chk("clr_eol", bus.d_eol, 1'b0);
    chk("clr_data_kept", bus.d_data, pk(22, 23, 1, 2));
    bus.d_ready = 1'b1;
    send(20); send(21); send(22);
    chk("post_clr_no_tile", bus.d_valid, 1'b0);
    send(23);
    expect_tile("post_clr", pk(20, 21, 22, 23), 1'b0);
    @(negedge clk);
    chk("clr_drain_count", drains - drains_before, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wc_tile_feeder.md
Name: wc_tile_feeder

Overview:
- Input-side transmitter for the Winograd F(2,3) convolution core (WC).
- Accepts a serial stream of signed samples, one per handshake, and builds overlapping 4-sample input tiles with stride 2 along each row.
- Presents each tile as the packed 4×DW word that WC consumes on D.
- Uses valid/ready on both sides, so upstream memory and the core can each stall independently.

Parameters:
- DW, 10: sample width in bits, two's complement.
- ROW_LEN, 16: samples per row. Must be even and ≥4. Tiles never straddle rows.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- clr  input  1  synchronous clear. Drops the partial tile and any pending output tile, and resets the column count to 0.
- s_data  input  DW  incoming sample.
- s_valid  input  1  s_data is valid.
- s_ready  output  1  feeder accepts s_data this cycle.
- d_data  output  4*DW  tile to WC. [DW-1:0] is the oldest sample d0; [4*DW-1:3*DW] is the newest sample d3.
- d_valid  output  1  d_data holds an unconsumed tile.
- d_ready  input  1  WC takes the tile this cycle.
- d_eol  output  1  qualifies d_valid: this tile is the last one of its row.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: d_valid=0, d_data=0, d_eol=0. s_ready=1 once rst is released.
  - Internal: tile buffer=0, fill=0, col=0.
- Sample accept: a sample is accepted when s_valid && s_ready. The accepted sample is written to buffer slot `fill`, fill is incremented, and col is incremented.
- Tile completion: when fill reaches 4 on an accept:
  - In the next cycle, d_data={b3,b2,b1,b0} and d_valid=1. Latency is one cycle from the accept of the completing sample.
  - d_eol=1 when the completing sample had col==ROW_LEN-1.
- After completion, mid-row: b0←b2, b1←b3, fill=2, so the next tile overlaps by 2 samples.
- After completion, end of row: fill=0 and col=0, so the next row starts a fresh tile.
- Tiles per row = (ROW_LEN-2)/2. Because ROW_LEN is even, the last sample of a row always completes a tile.
- s_ready rule:
  - s_ready=0 only when fill==3 && d_valid && !d_ready, i.e. the sample would complete a tile while the output register is occupied and not draining.
  - Otherwise s_ready=1.
  - This gives a combinational path from d_ready to s_ready. A drain and the accept of the completing sample may happen in the same cycle; the new tile appears in the next cycle.
- Output register:
  - d_valid clears on d_ready with no new completion.
  - When a drain and a completion coincide, d_valid stays 1 and d_data/d_eol load the new tile.
  - d_data and d_eol hold stable while d_valid && !d_ready.
- s_valid with s_ready=0: no state change. Upstream must hold s_data.
- clr:
  - clr=1 forces d_valid=0, d_eol=0, fill=0, col=0 at the next edge. d_data is left unchanged.
  - s_ready=0 during clr, so no sample is accepted in that cycle.
  - clr has priority over all simultaneous events.
- Arithmetic: samples are transported bit-exact, with no sign extension or arithmetic. Negative values are passed through unchanged.
- Reset mid-operation: the partial tile and pending tile are discarded. The first sample after reset is d0 of a new row.

Decomposition:
- Shared package wc_pkg holds:
  - localparams TILE=4, STEP=2, and default DW=10.
  - A function for the col counter width: clog2(ROW_LEN).
  - The tile typedef: packed array [TILE-1:0] of logic signed [DW-1:0].
  - WC and any output-side collector import the same package.
- Sub-module wc_tile_outreg: a 1-entry valid/ready output register with load/drain/hold. It is reused by the future output collector. The window buffer and counters stay in wc_tile_feeder.

Test Plan:
- Reset: hold rst=0 for 3 cycles with s_valid=1 → d_valid=0, d_data=0, d_eol=0 throughout. After release, s_ready=1.
- Steady stream: ROW_LEN=8, d_ready=1, samples 1..8 back-to-back → three tiles:
  - {1,2,3,4}: d_data=4<<30|3<<20|2<<10|1, one cycle after sample 4.
  - {3,4,5,6}, one cycle after sample 6.
  - {5,6,7,8} with d_eol=1, one cycle after sample 8.
  - d_eol=0 on the first two tiles.
- Backpressure: d_ready=0 after tile {1,2,3,4}; offer 5 then 6.
  - 5 is accepted; s_ready=0 while 6 is offered, and d_data stays {1,2,3,4}.
  - Raise d_ready → tile drains and 6 is accepted in the same cycle; {3,4,5,6} appears next cycle.
- Row boundary: ROW_LEN=8, samples 1..16 continuous → 6 tiles. The 4th tile is {9,10,11,12}. No tile {7,8,9,10} is produced. d_eol=1 on tiles 3 and 6.
- Signed extremes: samples 10'h200,10'h1FF,10'h000,10'h3FF → d_data=40'hFF_C0_07_FE_00. The bits of -512, 511, 0 and -1 appear unchanged.
- Reset/clr mid-row:
  - After samples 1,2,3, pulse rst low, then send 20..23 → tile {20,21,22,23}.
  - Repeat with clr instead of rst → same result, and a pending tile present at clr is never seen by d_ready.
